// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer: latches one instruction, reads operands from the
// register file, drives the ALU, then performs write-back or resolves the next PC.
module alu_exec_ctrl #(
  parameter int RF_READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_c,
  input  logic        alu_zero,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_next_pc,
  output logic        out_taken,
  output logic        out_illegal,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. in_ready is high only in IDLE; out_valid/out_* hold steady in RESP until
  // the out_ready edge, and a new instruction is never taken in that same cycle.

  if (RF_READ_LAT != 1) begin : g_lat_check
    $error("alu_exec_ctrl: only RF_READ_LAT = 1 is supported");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  logic [5:0]  opcode;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] pc_inc;
  logic [31:0] br_target;

  logic        wr_rd;
  logic        wr_rt;
  logic        is_br;
  logic        is_jmp;
  logic        is_ill;
  logic        b_sext;
  logic        b_zext;

  logic [4:0]  wr_addr_d;
  logic        wr_en_d;
  logic        br_taken;
  logic        taken_d;
  logic [31:0] next_pc_d;

  assign opcode          = instr_q[31:26];
  assign imm_sext        = {{16{instr_q[15]}}, instr_q[15:0]};
  assign imm_zext        = {16'd0, instr_q[15:0]};
  assign pc_inc          = pc_q + 32'd1;
  assign br_target       = pc_q + 32'd1 + imm_sext;

  assign rf_raddr1       = instr_q[25:21];
  assign rf_raddr2       = instr_q[20:16];
  assign alu_instruction = instr_q;
  assign dbg_state       = state;

  always_comb begin
    wr_rd  = 1'b0;
    wr_rt  = 1'b0;
    is_br  = 1'b0;
    is_jmp = 1'b0;
    is_ill = 1'b0;
    b_sext = 1'b0;
    b_zext = 1'b0;
    case (opcode) inside
      6'd0, 6'd1, 6'd2, 6'd3, 6'd6, 6'd7, 6'd10, 6'd11, 6'd23: wr_rd = 1'b1;
      6'd4, 6'd5, 6'd24: begin
        wr_rt  = 1'b1;
        b_sext = 1'b1;
      end
      6'd8, 6'd9: begin
        wr_rt  = 1'b1;
        b_zext = 1'b1;
      end
      [6'd14:6'd19]: is_br  = 1'b1;
      [6'd20:6'd22]: is_jmp = 1'b1;
      [6'd25:6'd63]: is_ill = 1'b1;
      default: ;
    endcase
  end

  // Operands are only presented in EX, so the ALU port idles at zero otherwise.
  always_comb begin
    alu_a = 32'd0;
    alu_b = 32'd0;
    if (state == S_EX) begin
      alu_a = rf_rdata1;
      if (b_sext)      alu_b = imm_sext;
      else if (b_zext) alu_b = imm_zext;
      else             alu_b = rf_rdata2;
    end
  end

  always_comb begin
    wr_addr_d = 5'd0;
    if (wr_rd)      wr_addr_d = instr_q[15:11];
    else if (wr_rt) wr_addr_d = instr_q[20:16];
    wr_en_d   = (wr_rd || wr_rt) && (wr_addr_d != 5'd0);
    br_taken  = is_br && !alu_zero;
    taken_d   = is_jmp || br_taken;
    next_pc_d = pc_inc;
    if (is_jmp)        next_pc_d = {6'd0, instr_q[25:0]};
    else if (br_taken) next_pc_d = br_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= 32'd0;
      pc_q        <= 32'd0;
      in_ready    <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= 32'd0;
      out_valid   <= 1'b0;
      out_next_pc <= 32'd0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            instr_q  <= in_instr;
            pc_q     <= in_pc;
            in_ready <= 1'b0;
            state    <= S_RD;
          end
        end
        S_RD: state <= S_EX;
        S_EX: begin
          rf_wdata    <= alu_c;
          rf_waddr    <= wr_addr_d;
          rf_we       <= wr_en_d;
          out_next_pc <= next_pc_d;
          out_taken   <= taken_d;
          out_illegal <= is_ill;
          out_valid   <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: stand-in ALU and register file, directed cases from the
// behaviour description plus randomized instructions against a reference model.
module tb_alu_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] alu_instruction;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_c;
  logic        alu_zero;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_next_pc;
  logic        out_taken;
  logic        out_illegal;
  logic [1:0]  dbg_state;

  alu_exec_ctrl #(.RF_READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_instruction(alu_instruction), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_zero(alu_zero),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_next_pc(out_next_pc), .out_taken(out_taken), .out_illegal(out_illegal),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stand-in register file and ALU ----------------
  logic [31:0] regs [32];

  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
  end

  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      6'd0, 6'd4, 6'd23, 6'd24: return a + b;
      6'd1, 6'd5:               return a - b;
      6'd2, 6'd8:               return a & b;
      6'd3, 6'd9:               return a | b;
      6'd6:                     return a ^ b;
      6'd7:                     return a << b[4:0];
      6'd10:                    return a >> b[4:0];
      6'd11, 6'd16:             return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd14:                    return (a != b) ? 32'd1 : 32'd0;
      6'd15:                    return (a == b) ? 32'd1 : 32'd0;
      6'd17:                    return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      6'd18:                    return (a < b) ? 32'd1 : 32'd0;
      6'd19:                    return (a >= b) ? 32'd1 : 32'd0;
      default:                  return a ^ b;
    endcase
  endfunction

  always_comb begin
    alu_c    = alu_fn(alu_instruction[31:26], alu_a, alu_b);
    alu_zero = (alu_c == 32'd0);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] model_b(input logic [31:0] instr);
    int op;
    op = int'(instr[31:26]);
    if (op == 4 || op == 5 || op == 24) return sext16(instr[15:0]);
    if (op == 8 || op == 9)             return {16'd0, instr[15:0]};
    return regs[instr[20:16]];
  endfunction

  // Packed expectation: {we, waddr[4:0], wdata[31:0], next_pc[31:0], taken, illegal}
  function automatic logic [71:0] model(input logic [31:0] instr, input logic [31:0] pc);
    int          op;
    logic [31:0] c;
    logic        we;
    logic [4:0]  dst;
    logic [31:0] nxt;
    logic        tk;
    logic        ill;
    op  = int'(instr[31:26]);
    c   = alu_fn(instr[31:26], regs[instr[25:21]], model_b(instr));
    we  = 1'b0;
    dst = 5'd0;
    nxt = pc + 32'd1;
    tk  = 1'b0;
    ill = 1'b0;
    if (op inside {0, 1, 2, 3, 6, 7, 10, 11, 23}) begin
      dst = instr[15:11];
      we  = (dst != 5'd0);
    end else if (op inside {4, 5, 8, 9, 24}) begin
      dst = instr[20:16];
      we  = (dst != 5'd0);
    end else if (op >= 14 && op <= 19) begin
      if (c != 32'd0) begin
        tk  = 1'b1;
        nxt = pc + 32'd1 + sext16(instr[15:0]);
      end
    end else if (op >= 20 && op <= 22) begin
      tk  = 1'b1;
      nxt = {6'd0, instr[25:0]};
    end else if (op >= 25) begin
      ill = 1'b1;
    end
    return {we, dst, c, nxt, tk, ill};
  endfunction

  // ---------------- scoreboard ----------------
  logic [71:0] exp_q[$];
  int          checks;
  int          errors;
  logic        last_we;
  logic [4:0]  last_waddr;
  logic [31:0] last_wdata;
  logic [31:0] last_next_pc;
  logic        last_taken;
  logic        last_illegal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_instr(input logic [31:0] instr, input logic [31:0] pc, input int stall);
    logic [71:0] e;
    logic [31:0] e_wdata;
    logic [31:0] e_next;
    logic [4:0]  rs;
    logic [4:0]  rt;
    wait_ready();
    if (!in_ready) return;
    rs        = instr[25:21];
    rt        = instr[20:16];
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = (stall == 0);
    exp_q.push_back(model(instr, pc));
    @(posedge clk);
    @(negedge clk);
    // RD: inputs are scrambled here and must not disturb the latched instruction
    in_valid = 1'($urandom_range(0, 1));
    in_instr = $urandom;
    in_pc    = $urandom;
    check("rd_in_ready", 32'(in_ready), 32'd0);
    check("rd_out_valid", 32'(out_valid), 32'd0);
    check("rd_rf_we", 32'(rf_we), 32'd0);
    check("rd_raddr1", 32'(rf_raddr1), 32'(rs));
    check("rd_raddr2", 32'(rf_raddr2), 32'(rt));
    @(negedge clk);
    check("ex_instr", alu_instruction, instr);
    check("ex_alu_a", alu_a, regs[rs]);
    check("ex_alu_b", alu_b, model_b(instr));
    check("ex_out_valid", 32'(out_valid), 32'd0);
    check("ex_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    e       = exp_q.pop_front();
    e_wdata = e[65:34];
    e_next  = e[33:2];
    check("resp_out_valid", 32'(out_valid), 32'd1);
    check("resp_in_ready", 32'(in_ready), 32'd0);
    check("resp_rf_we", 32'(rf_we), 32'(e[71]));
    if (e[71]) begin
      check("resp_waddr", 32'(rf_waddr), 32'(e[70:66]));
      check("resp_wdata", rf_wdata, e_wdata);
    end
    check("resp_next_pc", out_next_pc, e_next);
    check("resp_taken", 32'(out_taken), 32'(e[1]));
    check("resp_illegal", 32'(out_illegal), 32'(e[0]));
    last_we      = rf_we;
    last_waddr   = rf_waddr;
    last_wdata   = rf_wdata;
    last_next_pc = out_next_pc;
    last_taken   = out_taken;
    last_illegal = out_illegal;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_rf_we", 32'(rf_we), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_next_pc", out_next_pc, e_next);
      check("stall_taken", 32'(out_taken), 32'(e[1]));
      check("stall_illegal", 32'(out_illegal), 32'(e[0]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_rf_we", 32'(rf_we), 32'd0);
  endtask

  task automatic reset_during_ex();
    wait_ready();
    if (!in_ready) return;
    regs[1]  = 32'd5;
    regs[2]  = 32'd7;
    in_valid = 1'b1;
    in_instr = mk_r(6'd0, 5'd1, 5'd2, 5'd3);
    in_pc    = 32'h40;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_ex_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_state_idle", 32'(dbg_state), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_rf_we", 32'(rf_we), 32'd0);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("rel2_rf_we", 32'(rf_we), 32'd0);
    check("rel2_state", 32'(dbg_state), 32'd0);
  endtask

  task automatic randomize_regs();
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    regs[0] = 32'd0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    out_ready = 1'b1;
    randomize_regs();
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_taken", 32'(out_taken), 32'd0);
    check("reset_illegal", 32'(out_illegal), 32'd0);
    check("reset_next_pc", out_next_pc, 32'd0);
    check("reset_waddr", 32'(rf_waddr), 32'd0);
    check("reset_wdata", rf_wdata, 32'd0);
    check("reset_alu_instr", alu_instruction, 32'd0);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_alu_b", alu_b, 32'd0);
    check("reset_raddr1", 32'(rf_raddr1), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // directed cases
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    run_instr(mk_r(6'd0, 5'd1, 5'd2, 5'd3), 32'h10, 0);
    check("add_we", 32'(last_we), 32'd1);
    check("add_waddr", 32'(last_waddr), 32'd3);
    check("add_wdata", last_wdata, 32'd12);
    check("add_next_pc", last_next_pc, 32'h11);
    check("add_taken", 32'(last_taken), 32'd0);

    run_instr(mk_i(6'd4, 5'd1, 5'd4, 16'hFFFE), 32'h20, 0);
    check("sext_waddr", 32'(last_waddr), 32'd4);
    check("sext_wdata", last_wdata, 32'd3);

    run_instr(mk_i(6'd9, 5'd0, 5'd5, 16'h8000), 32'h21, 1);
    check("zext_wdata", last_wdata, 32'h0000_8000);

    regs[7] = 32'd9;
    regs[8] = 32'd9;
    run_instr(mk_i(6'd15, 5'd7, 5'd8, 16'hFFFC), 32'h100, 0);
    check("br15_taken", 32'(last_taken), 32'd1);
    check("br15_next_pc", last_next_pc, 32'hFD);
    run_instr(mk_i(6'd14, 5'd7, 5'd8, 16'hFFFC), 32'h100, 0);
    check("br14_taken", 32'(last_taken), 32'd0);
    check("br14_next_pc", last_next_pc, 32'h101);

    run_instr({6'd21, 26'h3FF_FFFF}, 32'h200, 0);
    check("jmp_taken", 32'(last_taken), 32'd1);
    check("jmp_next_pc", last_next_pc, 32'h03FF_FFFF);

    run_instr(mk_r(6'd0, 5'd1, 5'd2, 5'd3), 32'h300, 5);
    run_instr(mk_r(6'd0, 5'd1, 5'd2, 5'd0), 32'h301, 0);
    check("r0_no_write", 32'(last_we), 32'd0);

    run_instr(mk_r(6'd30, 5'd1, 5'd2, 5'd3), 32'h400, 0);
    check("ill_flag", 32'(last_illegal), 32'd1);
    check("ill_no_write", 32'(last_we), 32'd0);
    check("ill_next_pc", last_next_pc, 32'h401);

    run_instr(mk_i(6'd15, 5'd7, 5'd8, 16'h0000), 32'hFFFF_FFFF, 0);
    check("wrap_next_pc", last_next_pc, 32'h0000_0000);

    reset_during_ex();

    // randomized instructions
    for (int n = 0; n < 60; n++) begin
      if (n % 8 == 0) randomize_regs();
      if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(25, 63));
      else                           op = 6'($urandom_range(0, 24));
      rs = 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom_range(0, 31));
      run_instr({op, rs, rt, 16'($urandom)}, $urandom, $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle execute sequencer that drives the `alu` block. It accepts one decoded-stage instruction at a time and reads its operands from the register file. It presents the opcode and operands to the ALU, then consumes the ALU `c`/`zero` result to perform register write-back or resolve branches and jumps. It sits between fetch/decode and the register file, and is the initiator side of the ALU interface.

## Interface
- `RF_READ_LAT`, 1, register-file read latency in cycles; only value 1 is supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: high only in IDLE.
- `in_instr` in 32: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm, [25:0] jump index.
- `in_pc` in 32: word address of the instruction.
- `rf_raddr1`, `rf_raddr2` out 5: rs, rt from the latched instruction.
- `rf_rdata1`, `rf_rdata2` in 32: valid one cycle after the address.
- `alu_instruction` out 32: latched instruction.
- `alu_a` out 32: operand A to the ALU.
- `alu_b` out 32: operand B to the ALU.
- `alu_c` in 32: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: write address.
- `rf_wdata` out 32: write data.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `out_next_pc` out 32: resolved next PC.
- `out_taken` out 1: branch or jump taken.
- `out_illegal` out 1: opcode 25..63.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch `in_instr`/`in_pc` and go to RD.
  - RD: drive `rf_raddr1`/`rf_raddr2`; go to EX.
  - EX: drive `alu_a`/`alu_b`; register `alu_c`, `alu_zero`, write address/enable, next_pc, taken, illegal; go to RESP.
  - RESP: `out_valid`=1; go to IDLE when `out_ready`=1.
- `alu_a` = `rf_rdata1`.
- `alu_b` by opcode:
  - 4, 5, 24: sign-extended imm.
  - 8, 9: zero-extended imm.
  - all others: `rf_rdata2`.
- Write-back:
  - Opcodes 0-3, 6, 7, 10, 11, 23 write to rd.
  - Opcodes 4, 5, 8, 9, 24 write to rt.
  - `rf_wdata` = registered `alu_c`.
  - Writes to address 0 are suppressed (`rf_we` stays 0).
- Opcodes 12, 13 (memory ops): no write, not taken.
- Branches, opcodes 14-19: taken when `alu_zero`=0. Taken `out_next_pc` = `in_pc`+1+sext(imm); otherwise `in_pc`+1. Arithmetic is 32-bit modulo, wraps silently.
- Jumps, opcodes 20-22: taken=1; `out_next_pc` = {6'b0, instr[25:0]}.
- Illegal, opcodes 25-63: `out_illegal`=1, no write, not taken, `out_next_pc`=`in_pc`+1.
- Non-branch, non-jump opcodes: `out_next_pc`=`in_pc`+1.

## Timing
- Acceptance is the edge where `in_valid && in_ready`.
- RD is cycle +1, EX is cycle +2, RESP is entered at cycle +3. Minimum occupancy is 4 cycles per instruction.
- `rf_we` is a single-cycle pulse in the first RESP cycle only. It is never re-asserted while RESP is stalled.
- `out_*` are stable from RESP entry until the `out_ready` handshake edge.
- `in_ready` goes high the cycle after the handshake. There is no same-cycle accept in RESP.
- `in_valid` is ignored outside IDLE. The latched instruction is unaffected by `in_instr` changes.
- Reset values: state IDLE; `in_ready`, `out_valid`, `rf_we`, `out_taken`, `out_illegal` = 0; all address, data and PC outputs = 0. `in_ready` rises the first cycle after `rst` falls.
- Reset in any state returns to IDLE on that edge. No `rf_we` pulse follows, and the in-flight instruction is discarded.

## Test plan
- Add: r1=5, r2=7, instr op 0 rs1 rt2 rd3, pc=0x10. Expect `rf_we` pulse with waddr 3, wdata 12, 3 cycles after accept; `out_next_pc`=0x11, taken=0.
- Immediate extension:
  - Op 4, rs=r1=5, imm=0xFFFE: expect write rt, wdata 3.
  - Op 9, imm=0x8000, r1=0: expect wdata 0x00008000.
- Branches:
  - Op 15, r1=r2=9, imm=0xFFFC, pc=0x100: expect taken=1, next_pc=0xFD.
  - Op 14, same operands: expect taken=0, next_pc=0x101.
  - Op 21, index 0x3FFFFFF: expect taken=1, next_pc=0x03FFFFFF.
- Backpressure and r0:
  - `out_ready` low 5 cycles: `out_valid` and outputs held, `rf_we` exactly one pulse, `in_ready`=0 throughout.
  - Op 0 with rd=0: no write.
- Illegal opcode and reset:
  - Op 30: `out_illegal`=1, no write, next_pc=pc+1.
  - `rst` asserted during EX: next cycle IDLE, no `rf_we`, `out_valid`=0, `in_ready`=1 after release.
